data_memory_bs: RTL and testbench

// - Parametrised byte-addressed data memory for the CPU's MEM stage; successor of the fixed 64-byte word-only memory.
// - Adds byte/half/word access with sign/zero extension, a req/ready handshake, a registered read port,
//   out-of-range detection, and a post-reset zero-fill sweep.
// - Byte order is big-endian: mem[a] is DataOut[31:24] for a word access.

---
 rtl/dmem_pkg.sv | 23 ++
 rtl/dmem_lane_align.sv | 61 ++++++
 rtl/data_memory_bs.sv | 150 +++++++++++++++
 tb/tb_data_memory_bs.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-addressed data memory: access size codes,
// controller state encoding and an index-width helper.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } dsize_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } dstate_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for the big-endian data memory.
// Lane enable bit 3 is the lowest address of the word (DataOut[31:24]).
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_off,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    function automatic logic [31:0] ext_byte(input logic signed [7:0] v, input logic zx);
        return zx ? {24'h0, v} : 32'(v);
    endfunction

    function automatic logic [31:0] ext_half(input logic signed [15:0] v, input logic zx);
        return zx ? {16'h0, v} : 32'(v);
    endfunction

    logic signed [7:0]  ld_byte;
    logic signed [15:0] ld_half;

    always_comb begin
        st_be    = 4'b0000;
        st_wdata = st_data;
        case (st_size)
            SZ_BYTE: begin
                st_be    = 4'b1000 >> st_off;
                st_wdata = {4{st_data[7:0]}};
            end
            SZ_HALF: begin
                st_be    = st_off[1] ? 4'b0011 : 4'b1100;
                st_wdata = {2{st_data[15:0]}};
            end
            SZ_WORD: st_be = 4'b1111;
            default: st_be = 4'b0000;
        endcase
    end

    always_comb begin
        case (ld_off)
            2'd0:    ld_byte = ld_word[31:24];
            2'd1:    ld_byte = ld_word[23:16];
            2'd2:    ld_byte = ld_word[15:8];
            default: ld_byte = ld_word[7:0];
        endcase
        ld_half = ld_off[1] ? ld_word[15:0] : ld_word[31:16];
        case (ld_size)
            SZ_BYTE: ld_data = ext_byte(ld_byte, ld_unsigned);
            SZ_HALF: ld_data = ext_half(ld_half, ld_unsigned);
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/data_memory_bs.sv
// Byte-addressed data memory with req/ready handshake, registered read port and post-reset zero sweep.
// Optional macro DMEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into faults instead of force-aligning.
module data_memory_bs
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 256,
    parameter int ADDR_W      = 32
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              Req,
    input  logic              WE,
    input  logic [1:0]        Size,
    input  logic              Unsigned,
    input  logic [ADDR_W-1:0] DAddr,
    input  logic [31:0]       DataIn,
    output logic              Ready,
    output logic [31:0]       DataOut,
    output logic              RValid,
    output logic              Err
);

    localparam int                IDX_W     = clog2(DEPTH_BYTES);
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH_BYTES);
    localparam logic [IDX_W-1:0]  LAST_WORD = IDX_W'(DEPTH_BYTES - 4);

    logic [7:0]       mem [DEPTH_BYTES];
    dstate_e          state;
    logic [IDX_W-1:0] sweep_ptr;

    logic             accept;
    logic             fault;
    logic             size_bad;
    logic             oor;
    logic [ADDR_W:0]  span;
    logic [IDX_W-1:0] cur_idx;
    logic [IDX_W-1:0] wr_base;
    logic             wr_en;
    logic             sweep_en;
    logic [3:0]       st_be;
    logic [31:0]      st_wdata;

    logic             ld_vld_p0;
    logic             err_p0;
    logic [IDX_W-1:0] idx_p0;
    logic [1:0]       size_p0;
    logic             uns_p0;
    logic [IDX_W-1:0] rd_base;
    logic [31:0]      rd_word;
    logic [31:0]      ld_data;

    assign accept   = Req && Ready && !Reset;
    assign sweep_en = (state == ST_INIT) && !Reset;
    assign wr_en    = accept && WE && !fault;

`ifdef DMEM_MISALIGN_TRAP_EN
    logic misal;
`endif

    // Range is judged on the address as issued, so a straddling access faults even when force-aligned.
    always_comb begin
        case (Size)
            SZ_HALF: span = (ADDR_W+1)'(1);
            SZ_WORD: span = (ADDR_W+1)'(3);
            default: span = '0;
        endcase
        size_bad = (Size == 2'b11);
        oor      = ({1'b0, DAddr} + span) >= DEPTH_X;
        cur_idx  = DAddr[IDX_W-1:0];
`ifdef DMEM_MISALIGN_TRAP_EN
        misal = ((Size == SZ_HALF) && DAddr[0]) ||
                ((Size == SZ_WORD) && (DAddr[1:0] != 2'b00));
        fault = size_bad || oor || misal;
`else
        if (Size == SZ_HALF) cur_idx[0]   = 1'b0;
        if (Size == SZ_WORD) cur_idx[1:0] = 2'b00;
        fault = size_bad || oor;
`endif
        wr_base = cur_idx & ~IDX_W'(3);
    end

    dmem_lane_align u_align (
        .st_size    (Size),
        .st_off     (cur_idx[1:0]),
        .st_data    (DataIn),
        .st_be      (st_be),
        .st_wdata   (st_wdata),
        .ld_size    (size_p0),
        .ld_off     (idx_p0[1:0]),
        .ld_unsigned(uns_p0),
        .ld_word    (rd_word),
        .ld_data    (ld_data)
    );

    always_ff @(posedge CLK) begin
        if (sweep_en) begin
            for (int k = 0; k < 4; k++) mem[sweep_ptr | IDX_W'(k)] <= 8'h00;
        end else if (wr_en) begin
            for (int k = 0; k < 4; k++)
                if (st_be[3-k]) mem[wr_base | IDX_W'(k)] <= st_wdata[8*(3-k) +: 8];
        end
    end

    // Stage p0: accepted request captured; the array is read on the following edge.
    always_ff @(posedge CLK) begin
        if (accept) begin
            idx_p0  <= cur_idx;
            size_p0 <= Size;
            uns_p0  <= Unsigned;
        end
    end

    always_comb begin
        rd_base = idx_p0 & ~IDX_W'(3);
        rd_word = {mem[rd_base], mem[rd_base | IDX_W'(1)],
                   mem[rd_base | IDX_W'(2)], mem[rd_base | IDX_W'(3)]};
    end

    // Stage p1: controller, sweep and registered outputs.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state     <= ST_INIT;
            sweep_ptr <= '0;
            Ready     <= 1'b0;
            ld_vld_p0 <= 1'b0;
            err_p0    <= 1'b0;
            RValid    <= 1'b0;
            Err       <= 1'b0;
            DataOut   <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (sweep_ptr == LAST_WORD) begin
                        state <= ST_IDLE;
                        Ready <= 1'b1;
                    end else begin
                        sweep_ptr <= sweep_ptr + IDX_W'(4);
                    end
                end
                default: Ready <= 1'b1;
            endcase
            ld_vld_p0 <= accept && !WE;
            err_p0    <= accept && fault;
            RValid    <= ld_vld_p0;
            Err       <= err_p0;
            if (ld_vld_p0) DataOut <= err_p0 ? 32'h0 : ld_data;
        end
    end

endmodule

// File: tb/tb_data_memory_bs.sv
// Randomised self-checking bench for data_memory_bs against a byte-array reference model.
module tb_data_memory_bs;
    import dmem_pkg::*;

    localparam int DEPTH = 256;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        Req = 1'b0;
    logic        WE = 1'b0;
    logic [1:0]  Size = 2'b00;
    logic        Unsigned = 1'b0;
    logic [31:0] DAddr = 32'h0;
    logic [31:0] DataIn = 32'h0;
    logic        Ready;
    logic [31:0] DataOut;
    logic        RValid;
    logic        Err;

    data_memory_bs #(.DEPTH_BYTES(DEPTH), .ADDR_W(32)) dut (
        .CLK(CLK), .Reset(Reset), .Req(Req), .WE(WE), .Size(Size), .Unsigned(Unsigned),
        .DAddr(DAddr), .DataIn(DataIn), .Ready(Ready), .DataOut(DataOut),
        .RValid(RValid), .Err(Err)
    );

    always #5 CLK = ~CLK;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  mem_m [DEPTH];
    logic        pend_rv = 1'b0;
    logic        pend_err = 1'b0;
    logic [31:0] pend_dout = 32'h0;
    logic [31:0] last_dout = 32'h0;
    string       pend_tag = "init";
    logic [31:0] ra, rd;
    logic [1:0]  rs;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference: the access covers addr..addr+n-1 in big-endian order.
    task automatic model_op(input logic we, input logic [1:0] sz, input logic uns,
                            input logic [31:0] addr, input logic [31:0] data,
                            output logic err, output logic rv, output logic [31:0] dout);
        int          n;
        longint      last;
        logic [31:0] a;
        logic [31:0] v;
        n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
        err  = (n == 0);
        last = longint'(addr) + longint'(n) - 1;
        if (!err && last >= DEPTH) err = 1'b1;
        a = addr;
`ifdef DMEM_MISALIGN_TRAP_EN
        if (!err && (addr % 32'(n)) != 0) err = 1'b1;
`else
        if (!err) a = addr - (addr % 32'(n));
`endif
        rv   = !we;
        dout = 32'h0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < n; i++)
                    mem_m[8'(a + 32'(i))] = 8'(data >> (8 * (n - 1 - i)));
            end else begin
                v = 32'h0;
                for (int i = 0; i < n; i++) v = (v << 8) | 32'(mem_m[8'(a + 32'(i))]);
                if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
                dout = v;
            end
        end
    endtask

    task automatic cycle(input logic rq, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] d, input string tag);
        logic        rdy;
        logic        e_err, e_rv;
        logic [31:0] e_dout;
        Req = rq; WE = we; Size = sz; Unsigned = uns; DAddr = a; DataIn = d;
        rdy = Ready;
        @(posedge CLK);
        e_err = 1'b0; e_rv = 1'b0; e_dout = 32'h0;
        if (rq && rdy) model_op(we, sz, uns, a, d, e_err, e_rv, e_dout);
        #1;
        if (pend_rv) last_dout = pend_dout;
        check_val({pend_tag, "/rvalid"}, 32'(RValid), 32'(pend_rv));
        check_val({pend_tag, "/err"}, 32'(Err), 32'(pend_err));
        check_val({pend_tag, "/dout"}, DataOut, last_dout);
        pend_rv = e_rv; pend_err = e_err; pend_dout = e_dout; pend_tag = tag;
        @(negedge CLK);
    endtask

    task automatic do_reset(input int hold);
        int cnt;
        Req = 1'b0; Reset = 1'b1;
        repeat (hold) begin
            @(posedge CLK); #1;
            check_val("rst/rvalid", 32'(RValid), 32'd0);
            check_val("rst/err", 32'(Err), 32'd0);
            check_val("rst/ready", 32'(Ready), 32'd0);
        end
        check_val("rst/dout", DataOut, 32'h0);
        @(negedge CLK);
        Reset = 1'b0;
        cnt = 1;
        while (cnt < 1000) begin
            @(posedge CLK); #1;
            if (Ready) break;
            cnt++;
        end
        check_val("sweep_len", 32'(cnt), 32'd64);
        foreach (mem_m[i]) mem_m[i] = 8'h00;
        pend_rv = 1'b0; pend_err = 1'b0; last_dout = 32'h0; pend_tag = "post_rst";
        @(negedge CLK);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset(3);
        cycle(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, "lw_10");
        cycle(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h20, 32'h11223344, "sw_20");
        cycle(1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h20, 32'h0, "lb_20");
        cycle(1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h23, 32'h0, "lbu_23");
        cycle(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, "lw_20");
        cycle(1'b1, 1'b1, SZ_BYTE, 1'b0, 32'h41, 32'h80, "sb_41");
        cycle(1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h41, 32'h0, "lb_41");
        cycle(1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h41, 32'h0, "lbu_41");
        cycle(1'b1, 1'b1, SZ_HALF, 1'b0, 32'h42, 32'hBEEF, "sh_42");
        cycle(1'b1, 1'b0, SZ_HALF, 1'b0, 32'h42, 32'h0, "lh_42");
        cycle(1'b1, 1'b0, SZ_WORD, 1'b0, 32'hFE, 32'h0, "lw_fe");
        cycle(1'b0, 1'b0, SZ_BYTE, 1'b0, 32'h0, 32'h0, "idle");
        cycle(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h100, 32'hDEADBEEF, "sw_100");
        cycle(1'b1, 1'b1, SZ_WORD, 1'b0, 32'hFC, 32'hCAFEF00D, "sw_fc");
        cycle(1'b1, 1'b1, SZ_HALF, 1'b0, 32'hFF, 32'h1234, "sh_ff");
        cycle(1'b1, 1'b0, SZ_WORD, 1'b0, 32'hFC, 32'h0, "lw_fc");
        cycle(1'b1, 1'b1, 2'b11, 1'b0, 32'h44, 32'hFFFFFFFF, "s_bad");
        cycle(1'b1, 1'b0, 2'b11, 1'b0, 32'h40, 32'h0, "l_bad");
        cycle(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h44, 32'h0, "lw_44");
        cycle(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h21, 32'h0, "lw_21");
        cycle(1'b1, 1'b0, SZ_HALF, 1'b1, 32'h43, 32'h0, "lhu_43");
        cycle(1'b0, 1'b0, SZ_BYTE, 1'b0, 32'h0, 32'h0, "idle");

        for (int i = 0; i < 400; i++) begin
            ra = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, DEPTH + 8));
            rs = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            rd = $urandom;
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), rs,
                  1'($urandom_range(0, 1)), ra, rd, "rand");
        end
        cycle(1'b0, 1'b0, SZ_BYTE, 1'b0, 32'h0, 32'h0, "idle");

        // Reset lands on the cycle after an accepted load: that load's result must never appear.
        cycle(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h20, 32'h55667788, "sw_20b");
        cycle(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, "lw_pre_rst");
        do_reset(2);
        cycle(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, "lw_20_zero");

        Req = 1'b0; Reset = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        Reset = 1'b0;
        pend_rv = 1'b0; pend_err = 1'b0; last_dout = 32'h0; pend_tag = "sweep";
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'($urandom_range(0, 1)), SZ_WORD, 1'b0, 32'($urandom_range(0, 63)) << 2,
                  $urandom, "init_ign");
        end
        do_reset(1);
        cycle(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, "lw_20_swept");
        cycle(1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h41, 32'h0, "lb_41_swept");
        cycle(1'b0, 1'b0, SZ_BYTE, 1'b0, 32'h0, 32'h0, "idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
